// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue/writeback controller:
//   - MIPS opcode constants (OP_*) and R-type FUNC constants (FN_*)
//   - controller FSM state type and instruction class type
//   - classify(): maps an opcode to its writeback class
// -----------------------------------------------------------------------------
package alu_pkg;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // R-type function codes, instruction bits [5:0]
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } issue_state_e;

  typedef enum logic [1:0] {
    CLS_RTYPE,    // writes rd = ir[15:11]
    CLS_ITYPE,    // writes rt = ir[20:16]
    CLS_BRANCH,   // no write, reports the ALU branch condition
    CLS_ILLEGAL   // no write, flagged at retire
  } instr_class_e;

  function automatic instr_class_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE:                               return CLS_RTYPE;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:                return CLS_ITYPE;
      OP_BEQ, OP_BNE:                         return CLS_BRANCH;
      default:                                return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Bundles every non-clock signal of alu_issue_ctrl.
//   master : the controller (accepts INSTR, drives the ALU operand ports,
//            retire flags and DBG_DATA; receives ALU RESULT/SIG_B)
//   slave  : its environment (instruction source, ALU, debug reader)
// Optional: ALU_ISSUE_PERF_EN adds RETIRE_CNT and BRANCH_CNT.
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [31:0]       INSTR;
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic [5:0]        OPCODE;
  logic [DATA_W-1:0] RS_VAL;
  logic [DATA_W-1:0] RT_VAL;
  logic [4:0]        SHAMT;
  logic [5:0]        FUNC;
  logic [15:0]       RAW_VAL;
  logic [DATA_W-1:0] ALU_RESULT;
  logic              ALU_SIG_B;
  logic              RETIRE;
  logic              BRANCH_TAKEN;
  logic              ILLEGAL;
  logic [REG_AW-1:0] DBG_ADDR;
  logic [DATA_W-1:0] DBG_DATA;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]       RETIRE_CNT;
  logic [31:0]       BRANCH_CNT;
`endif

  modport master (
    input  INSTR, INSTR_VALID, ALU_RESULT, ALU_SIG_B, DBG_ADDR,
    output INSTR_READY, OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC, RAW_VAL,
           RETIRE, BRANCH_TAKEN, ILLEGAL, DBG_DATA
`ifdef ALU_ISSUE_PERF_EN
    , output RETIRE_CNT, BRANCH_CNT
`endif
  );

  modport slave (
    output INSTR, INSTR_VALID, ALU_RESULT, ALU_SIG_B, DBG_ADDR,
    input  INSTR_READY, OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC, RAW_VAL,
           RETIRE, BRANCH_TAKEN, ILLEGAL, DBG_DATA
`ifdef ALU_ISSUE_PERF_EN
    , input RETIRE_CNT, BRANCH_CNT
`endif
  );

endinterface

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// 2**REG_AW x DATA_W register file, register 0 hardwired to zero.
//   clk, rst_n              : clock, async active-low clear of all entries
//   rs_addr_i / rs_data_o   : async read port A
//   rt_addr_i / rt_data_o   : async read port B
//   dbg_addr_i / dbg_data_o : async debug read port
//   we_i, waddr_i, wdata_i  : sync write port (writes to entry 0 dropped)
// -----------------------------------------------------------------------------
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  input  logic [REG_AW-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rt_data_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] mem_q [NREG];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this storage must read as all-zero after reset, so it is built
      // from resettable flops instead of a RAM macro (which cannot be cleared).
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Entry 0 is never written; the explicit compare keeps r0 zero by
  // construction rather than relying on the write guard alone.
  assign rs_data_o  = (rs_addr_i  == '0) ? '0 : mem_q[rs_addr_i];
  assign rt_data_o  = (rt_addr_i  == '0) ? '0 : mem_q[rt_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Multi-cycle issue/writeback controller in front of a combinational ALU.
// One instruction at a time: IDLE (accept) -> DECODE -> EXEC -> WB, so the
// RETIRE pulse lands in the 4th cycle counting the accept cycle as the 1st.
//   CLK, RST_N : clock (rising edge), async active-low reset
//   bus        : alu_issue_ctrl_if.master -- INSTR valid/ready, ALU operand
//                ports, ALU RESULT/SIG_B, retire flags, debug register read
// Optional: define ALU_ISSUE_PERF_EN for RETIRE_CNT / BRANCH_CNT counters.
// -----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  alu_issue_ctrl_if.master bus
);

  // Operand bundle presented to the ALU; loaded in DECODE, held afterwards.
  typedef struct packed {
    logic [5:0]        opcode;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [4:0]        shamt;
    logic [5:0]        func;
    logic [15:0]       raw_val;
  } alu_ops_t;

  issue_state_e      state_q, state_d;
  logic              ready_q;
  logic [31:0]       ir_q, ir_d;
  alu_ops_t          ops_q, ops_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              br_q, br_d;

  logic [REG_AW-1:0] rs_addr, rt_addr, wr_addr;
  logic [DATA_W-1:0] rs_data, rt_data;
  instr_class_e      cls;
  logic              wr_en;
  logic              retire;
  logic              branch_taken;

  assign rs_addr = REG_AW'(ir_q[25:21]);
  assign rt_addr = REG_AW'(ir_q[20:16]);
  assign cls     = classify(ir_q[31:26]);

  // Writeback destination from the held instruction word.
  always_comb begin : dest_decode
    wr_en   = 1'b0;
    wr_addr = '0;
    case (cls)
      CLS_RTYPE: begin
        wr_en   = 1'b1;
        wr_addr = REG_AW'(ir_q[15:11]);
      end
      CLS_ITYPE: begin
        wr_en   = 1'b1;
        wr_addr = REG_AW'(ir_q[20:16]);
      end
      default: ;
    endcase
  end

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk        (CLK),
    .rst_n      (RST_N),
    .rs_addr_i  (rs_addr),
    .rs_data_o  (rs_data),
    .rt_addr_i  (rt_addr),
    .rt_data_o  (rt_data),
    .dbg_addr_i (bus.DBG_ADDR),
    .dbg_data_o (bus.DBG_DATA),
    .we_i       (retire && wr_en),
    .waddr_i    (wr_addr),
    .wdata_i    (res_q)
  );

  always_comb begin : fsm_next
    // NOTE: every variable gets its hold value first, so no path through the
    // case below leaves one unassigned and no latch is inferred.
    state_d = state_q;
    ir_d    = ir_q;
    ops_d   = ops_q;
    res_d   = res_q;
    br_d    = br_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.INSTR_VALID && ready_q) begin
          ir_d    = bus.INSTR;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ops_d.opcode  = ir_q[31:26];
        ops_d.rs_val  = rs_data;
        ops_d.rt_val  = rt_data;
        ops_d.shamt   = ir_q[10:6];
        ops_d.func    = ir_q[5:0];
        ops_d.raw_val = ir_q[15:0];
        state_d       = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = bus.ALU_RESULT;
        br_d    = bus.ALU_SIG_B;
        state_d = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      ir_q    <= '0;
      ops_q   <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered so READY is 0 during reset and rises on the first clock
      // after release, while still tracking the IDLE state exactly.
      ready_q <= (state_d == ST_IDLE);
      ir_q    <= ir_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
      br_q    <= br_d;
    end
  end

  assign retire       = (state_q == ST_WB);
  assign branch_taken = retire && (cls == CLS_BRANCH) && br_q;

  assign bus.INSTR_READY  = ready_q;
  assign bus.OPCODE       = ops_q.opcode;
  assign bus.RS_VAL       = ops_q.rs_val;
  assign bus.RT_VAL       = ops_q.rt_val;
  assign bus.SHAMT        = ops_q.shamt;
  assign bus.FUNC         = ops_q.func;
  assign bus.RAW_VAL      = ops_q.raw_val;
  assign bus.RETIRE       = retire;
  assign bus.BRANCH_TAKEN = branch_taken;
  assign bus.ILLEGAL      = retire && (cls == CLS_ILLEGAL);

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] retire_cnt_q, branch_cnt_q;

  // Free-running event counters; wrap naturally at 2**32.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      retire_cnt_q <= '0;
      branch_cnt_q <= '0;
    end else begin
      if (retire)       retire_cnt_q <= retire_cnt_q + 32'd1;
      if (branch_taken) branch_cnt_q <= branch_cnt_q + 32'd1;
    end
  end

  assign bus.RETIRE_CNT = retire_cnt_q;
  assign bus.BRANCH_CNT = branch_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Drives alu_issue_ctrl through its interface, plays the combinational ALU,
// and compares against an instruction-level model of the register file.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  alu_issue_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  alu_issue_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] model_rf [32];
  int          n_retire_m = 0;
  int          n_branch_m = 0;
  logic        alu_live;

  logic [5:0] fn_tab  [10] = '{FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB,
                               FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT};
  logic [5:0] ity_tab [7]  = '{OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                               OP_ORI, OP_XORI, OP_LUI};
  logic [5:0] ill_tab [5]  = '{6'b100011, 6'b101011, 6'b000010,
                               6'b001011, 6'b111111};

  // ---------------- behavioural MIPS ALU semantics ----------------
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [4:0] sh, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] imm);
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU: return a + b;
          FN_SUB:          return a - b;
          FN_AND:          return a & b;
          FN_OR:           return a | b;
          FN_XOR:          return a ^ b;
          FN_NOR:          return ~(a | b);
          FN_SLT:          return {31'b0, $signed(a) < $signed(b)};
          FN_SLL:          return b << sh;
          FN_SRL:          return b >> sh;
          default:         return 32'h0;
        endcase
      end
      OP_ADDI, OP_ADDIU: return a + sext16(imm);
      OP_SLTI:           return {31'b0, $signed(a) < $signed(sext16(imm))};
      OP_ANDI:           return a & {16'h0, imm};
      OP_ORI:            return a | {16'h0, imm};
      OP_XORI:           return a ^ {16'h0, imm};
      OP_LUI:            return {imm, 16'h0};
      default:           return a - b;
    endcase
  endfunction

  function automatic logic sigb_ref(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      default: return 1'b0;
    endcase
  endfunction

  // The bench ALU answers correctly only while the controller should be
  // sampling it (EXEC); elsewhere it returns corrupted values.
  logic [31:0] alu_val;
  logic        alu_sig;
  always_comb begin
    alu_val = alu_ref(bus.OPCODE, bus.FUNC, bus.SHAMT, bus.RS_VAL, bus.RT_VAL, bus.RAW_VAL);
    alu_sig = sigb_ref(bus.OPCODE, bus.RS_VAL, bus.RT_VAL);
  end
  assign bus.ALU_RESULT = alu_live ? alu_val : (alu_val ^ 32'hDEAD_BEEF);
  assign bus.ALU_SIG_B  = alu_live ? alu_sig : ~alu_sig;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dbg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.DBG_ADDR = addr;
    #1;
    check(tag, bus.DBG_DATA, exp);
  endtask

  task automatic check_rf_all(input string tag);
    for (int r = 0; r < 32; r++) begin
      bus.DBG_ADDR = r[4:0];
      #1;
      check($sformatf("%s_r%0d", tag, r), bus.DBG_DATA, model_rf[r]);
    end
    @(negedge CLK);
  endtask

  // Issues one instruction starting from a negedge in IDLE and follows it
  // cycle by cycle: accept, DECODE, EXEC, WB (RETIRE), back to IDLE.
  task automatic run_instr(input logic [31:0] instr, input bit hold_valid);
    logic [5:0]  op;
    logic [4:0]  rs, rt, dst;
    logic [31:0] a, b, exp_res;
    bit          wr, is_br, is_ill;
    logic        exp_br;
    op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16];
    a = model_rf[rs]; b = model_rf[rt];
    wr = 0; is_br = 0; is_ill = 0; dst = rt;
    case (op)
      OP_RTYPE: begin wr = 1; dst = instr[15:11]; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: wr = 1;
      OP_BEQ, OP_BNE: is_br = 1;
      default: is_ill = 1;
    endcase
    exp_res = alu_ref(op, instr[5:0], instr[10:6], a, b, instr[15:0]);
    exp_br  = is_br && sigb_ref(op, a, b);

    check("ready_idle", 32'(bus.INSTR_READY), 32'd1);
    bus.INSTR = instr;
    bus.INSTR_VALID = 1'b1;
    @(negedge CLK);  // cycle 2: DECODE
    if (!hold_valid) bus.INSTR_VALID = 1'b0;
    check("ready_decode",  32'(bus.INSTR_READY), 32'd0);
    check("retire_decode", 32'(bus.RETIRE), 32'd0);
    @(negedge CLK);  // cycle 3: EXEC
    alu_live = 1'b1;
    check("ready_exec",  32'(bus.INSTR_READY), 32'd0);
    check("retire_exec", 32'(bus.RETIRE), 32'd0);
    check("opcode",  32'(bus.OPCODE), 32'(op));
    check("rs_val",  bus.RS_VAL, a);
    check("rt_val",  bus.RT_VAL, b);
    check("shamt",   32'(bus.SHAMT), 32'(instr[10:6]));
    check("func",    32'(bus.FUNC), 32'(instr[5:0]));
    check("raw_val", 32'(bus.RAW_VAL), 32'(instr[15:0]));
    @(negedge CLK);  // cycle 4: WB
    alu_live = 1'b0;
    bus.INSTR_VALID = 1'b0;
    check("retire_wb",  32'(bus.RETIRE), 32'd1);
    check("branch_wb",  32'(bus.BRANCH_TAKEN), 32'(exp_br));
    check("illegal_wb", 32'(bus.ILLEGAL), 32'(is_ill));
    check("ready_wb",   32'(bus.INSTR_READY), 32'd0);
    check("rs_val_held", bus.RS_VAL, a);
    check("rt_val_held", bus.RT_VAL, b);
    @(negedge CLK);  // back in IDLE
    if (wr && dst != 5'd0) model_rf[dst] = exp_res;
    n_retire_m++;
    if (exp_br) n_branch_m++;
    check("retire_after", 32'(bus.RETIRE), 32'd0);
    check("ready_after",  32'(bus.INSTR_READY), 32'd1);
    check_dbg("dbg_dest", dst, model_rf[dst]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] instr;
    logic [4:0]  rs, rt, rd;
    int          sel;

    bus.INSTR = '0;
    bus.INSTR_VALID = 1'b0;
    bus.DBG_ADDR = '0;
    alu_live = 1'b0;
    for (int r = 0; r < 32; r++) model_rf[r] = '0;

    // Reset state, including READY staying low until the first clock after release.
    @(negedge CLK);
    check("rst_ready",  32'(bus.INSTR_READY), 32'd0);
    check("rst_retire", 32'(bus.RETIRE), 32'd0);
    check("rst_opcode", 32'(bus.OPCODE), 32'd0);
    check("rst_rs_val", bus.RS_VAL, 32'd0);
    check("rst_illeg",  32'(bus.ILLEGAL), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1 check("ready_pre_clk", 32'(bus.INSTR_READY), 32'd0);
    @(negedge CLK);
    check("ready_post_clk", 32'(bus.INSTR_READY), 32'd1);

    // addi $1,15 ; addi $2,12 ; and $3,$1,$2 -> 12
    run_instr(32'h2001000F, 1'b0);
    run_instr(32'h2002000C, 1'b0);
    run_instr(32'h00221824, 1'b0);
    check_dbg("and_15_12", 5'd3, 32'd12);
    // 23 & 2 -> 2
    run_instr(32'h20010017, 1'b0);
    run_instr(32'h20020002, 1'b0);
    run_instr(32'h00221824, 1'b0);
    check_dbg("and_23_2", 5'd3, 32'd2);
    // 1 & 35 -> 1
    run_instr(32'h20010001, 1'b0);
    run_instr(32'h20020023, 1'b0);
    run_instr(32'h00221824, 1'b0);
    check_dbg("and_1_35", 5'd3, 32'd1);
    // write to r0 is discarded
    run_instr(32'h20000005, 1'b0);
    check_dbg("r0_zero", 5'd0, 32'd0);
    // beq $1,$1 taken; bne $1,$1 not taken; lw illegal; none modify the RF
    run_instr(32'h10210004, 1'b0);
    run_instr(32'h14210004, 1'b0);
    run_instr(32'h8C220000, 1'b0);
    check_rf_all("directed");

    // Randomized instruction stream with idle gaps.
    for (int k = 0; k < 40; k++) begin
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 9));
      if (sel <= 4)
        instr = {OP_RTYPE, rs, rt, rd, 5'($urandom_range(0, 31)), fn_tab[$urandom_range(0, 9)]};
      else if (sel <= 7)
        instr = {ity_tab[$urandom_range(0, 6)], rs, rt, 16'($urandom)};
      else if (sel == 8)
        instr = {($urandom_range(0, 1) != 0) ? OP_BEQ : OP_BNE, rs,
                 ($urandom_range(0, 1) != 0) ? rs : rt, 16'($urandom)};
      else
        instr = {ill_tab[$urandom_range(0, 4)], rs, rt, 16'($urandom)};
      repeat ($urandom_range(0, 2)) begin
        bus.INSTR = $urandom;
        @(negedge CLK);
        check("ready_gap", 32'(bus.INSTR_READY), 32'd1);
      end
      run_instr(instr, 1'b0);
    end
    check_rf_all("random");
`ifdef ALU_ISSUE_PERF_EN
    check("retire_cnt", bus.RETIRE_CNT, 32'(n_retire_m));
    check("branch_cnt", bus.BRANCH_CNT, 32'(n_branch_m));
`endif

    // Reset during EXEC of addi $4,$0,7 after $4 was set to 9.
    run_instr(32'h20040009, 1'b0);
    bus.INSTR = 32'h20040007;
    bus.INSTR_VALID = 1'b1;
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    alu_live = 1'b1;
    RST_N = 1'b0;
    bus.DBG_ADDR = 5'd4;
    #1;
    alu_live = 1'b0;
    check("midrst_ready",  32'(bus.INSTR_READY), 32'd0);
    check("midrst_retire", 32'(bus.RETIRE), 32'd0);
    check("midrst_opcode", 32'(bus.OPCODE), 32'd0);
    check("midrst_rt_val", bus.RT_VAL, 32'd0);
    check("midrst_raw",    32'(bus.RAW_VAL), 32'd0);
    check("midrst_dbg4",   bus.DBG_DATA, 32'd0);
    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    n_retire_m = 0;
    n_branch_m = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("postrst_ready", 32'(bus.INSTR_READY), 32'd1);
    check_dbg("postrst_dbg4", 5'd4, 32'd0);
    check_rf_all("postrst");

    // VALID held high through the busy cycles: accepted exactly once.
    run_instr(32'h20A50001, 1'b1);
    check_dbg("busy_once", 5'd5, 32'd1);
    @(negedge CLK);
    check("busy_ready", 32'(bus.INSTR_READY), 32'd1);
`ifdef ALU_ISSUE_PERF_EN
    check("retire_cnt_rst", bus.RETIRE_CNT, 32'(n_retire_m));
    check("branch_cnt_rst", bus.BRANCH_CNT, 32'(n_branch_m));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
